// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Valid/ready byte intake; one baud-period counter paces every bit.
module uart_tx_engine #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned DIV   = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 bit_end;

  assign bit_end  = (baud_cnt == CNT_MAX);
  assign tx_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != S_IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            state    <= S_START;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= tx_data;
            // Parity is frozen from the accepted byte, not the live input
            par_bit  <= (PARITY == 1) ? ~^tx_data : ^tx_data;
          end
        end
        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            tx    <= shift[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == BIT_MAX) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= S_PAR;
                tx    <= par_bit;
              end else begin
                state    <= S_STOP;
                tx       <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
        S_PAR: begin
          if (bit_end) begin
            state    <= S_STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (stop_idx == STOP_LAST) begin
              state   <= S_IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: four instances cover no/odd/even parity,
// two stop bits, back-to-back frames, busy-time stimulus and mid-frame reset.
module tb_uart_tx_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] reset;
  logic [3:0] valid;
  logic [7:0] data [4];
  wire  [3:0] tx_w, ready_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;

  // inst 0: DIV=(1_050_000+50_000)/100_000=11 (rounded), no parity, 1 stop
  uart_tx_engine #(.CLK_FREQ(1_050_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1)) u_tx0 (
    .clk(clk), .reset(reset[0]), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx_engine #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1)) u_tx1 (
    .clk(clk), .reset(reset[1]), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx_engine #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1)) u_tx2 (
    .clk(clk), .reset(reset[2]), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  uart_tx_engine #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(2)) u_tx3 (
    .clk(clk), .reset(reset[3]), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends one frame starting at a negedge; returns at the negedge after frame end.
  task automatic run_frame(input int idx, input int div, input int par, input int stop,
                           input logic [7:0] b, input bit hold, input logic [7:0] next_b,
                           input bit disturb, input string tag);
    logic exp_bits [12];
    int   nb;
    int   len;
    bit   done_early = 1'b0;
    bit   ready_high = 1'b0;
    bit   busy_low   = 1'b0;
    check({tag, "_ready_before"}, 32'(ready_w[idx]), 32'd1);
    data[idx]  = b;
    valid[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold) data[idx] = next_b;
    else      valid[idx] = 1'b0;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = b[i];
    nb = 9;
    if (par != 0) begin
      exp_bits[9] = (par == 1) ? ~^b : ^b;
      nb = 10;
    end
    for (int s = 0; s < stop; s++) exp_bits[nb+s] = 1'b1;
    nb  = nb + stop;
    len = div * nb;
    check({tag, "_tx_fall"}, 32'(tx_w[idx]), 32'd0);
    check({tag, "_busy_rise"}, 32'(busy_w[idx]), 32'd1);
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      if (c % div == div / 2)
        check($sformatf("%s_bit%0d", tag, c / div), 32'(tx_w[idx]), 32'(exp_bits[c / div]));
      if (done_w[idx])  done_early = 1'b1;
      if (ready_w[idx]) ready_high = 1'b1;
      if (!busy_w[idx]) busy_low   = 1'b1;
      if (disturb && c == 3 * div) begin
        data[idx]  = ~b;
        valid[idx] = 1'b1;
      end
      if (disturb && c == 3 * div + 1) valid[idx] = 1'b0;
    end
    @(negedge clk);
    check({tag, "_no_early_done"}, 32'(done_early), 32'd0);
    check({tag, "_ready_low_in_frame"}, 32'(ready_high), 32'd0);
    check({tag, "_busy_in_frame"}, 32'(busy_low), 32'd0);
    check({tag, "_done"}, 32'(done_w[idx]), 32'd1);
    check({tag, "_busy_end"}, 32'(busy_w[idx]), 32'd0);
    check({tag, "_ready_end"}, 32'(ready_w[idx]), 32'd1);
    check({tag, "_tx_idle"}, 32'(tx_w[idx]), 32'd1);
  endtask

  initial begin
    bit bad_after_reset;
    reset = 4'hF;
    valid = 4'h0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    @(negedge clk);
    reset = 4'h0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst%0d_tx", i), 32'(tx_w[i]), 32'd1);
      check($sformatf("rst%0d_ready", i), 32'(ready_w[i]), 32'd1);
      check($sformatf("rst%0d_busy", i), 32'(busy_w[i]), 32'd0);
      check($sformatf("rst%0d_done", i), 32'(done_w[i]), 32'd0);
    end

    // Back-to-back: 0x08 then 0x01 with valid held high
    run_frame(0, 11, 0, 1, 8'h08, 1'b1, 8'h01, 1'b0, "b2b_first");
    run_frame(0, 11, 0, 1, 8'h01, 1'b0, 8'h00, 1'b0, "b2b_second");
    @(negedge clk);
    check("b2b_done_one_cycle", 32'(done_w[0]), 32'd0);

    run_frame(1, 10, 2, 1, 8'h07, 1'b0, 8'h00, 1'b0, "even_par");
    run_frame(2, 10, 1, 1, 8'h07, 1'b0, 8'h00, 1'b0, "odd_par");
    run_frame(3, 10, 0, 2, 8'hA5, 1'b0, 8'h00, 1'b0, "two_stop");
    @(negedge clk);
    check("two_stop_done_one_cycle", 32'(done_w[3]), 32'd0);

    // Input changes and a valid pulse while busy must not disturb the frame
    run_frame(0, 11, 0, 1, 8'hC3, 1'b0, 8'h00, 1'b1, "busy_ignore");
    @(negedge clk);

    // Reset during data bit 3 (cycles 44..54 after accept for DIV=11)
    data[0]  = 8'h35;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (46) @(negedge clk);
    check("midrst_bit3_before", 32'(tx_w[0]), 32'd0);
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    check("midrst_tx", 32'(tx_w[0]), 32'd1);
    check("midrst_ready", 32'(ready_w[0]), 32'd1);
    check("midrst_busy", 32'(busy_w[0]), 32'd0);
    check("midrst_done", 32'(done_w[0]), 32'd0);
    bad_after_reset = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done_w[0] || !tx_w[0] || busy_w[0]) bad_after_reset = 1'b1;
    end
    check("midrst_quiet", 32'(bad_after_reset), 32'd0);
    run_frame(0, 11, 0, 1, 8'h55, 1'b0, 8'h00, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
